cr_kme_fifo_ng: RTL
===================

// Module: cr_kme_fifo_ng
// PURPOSE
//  Next-generation KME staging FIFO with self-contained storage. Depth may be any value, not only a power of two.
//  Adds programmable stall threshold, optional stall override, synchronous clear, occupancy outputs.
//  Fall-through output: head entry is visible while fifo_out_valid=1. Sits between KME pipeline stages.
// PARAMETERS
//  DATA_SIZE    128  entry width in bits
//  FIFO_DEPTH   3    entries, >=2, any integer
//  STALL_AT     0    fifo_in_stall asserted when free_slots <= STALL_AT; legal range 0..FIFO_DEPTH-1
//  OVERRIDE_EN  0    1: fifo_in_stall_override is honoured; 0: it is ignored
// PORTS
//  clk                     in   1          clock
//  rst_n                   in   1          async active-low reset
//  clear                   in   1          sync flush, empties FIFO
//  fifo_in                 in   DATA_SIZE  write data
//  fifo_in_valid           in   1          write strobe (wen)
//  fifo_in_stall_override  in   1          force stall (OVERRIDE_EN=1 only)
//  fifo_in_stall           out  1          backpressure to writer
//  fifo_out                out  DATA_SIZE  head entry, 0 when empty
//  fifo_out_valid          out  1          FIFO non-empty
//  fifo_out_ack            in   1          pop head when valid
//  fifo_overflow           out  1          1-cycle pulse: write dropped
//  fifo_underflow          out  1          1-cycle pulse: ack while empty
//  used_slots              out  CNT_W      occupancy, CNT_W=$clog2(FIFO_DEPTH+1)
//  free_slots              out  CNT_W      FIFO_DEPTH-used_slots
//  hwm_slots               out  CNT_W      high-watermark (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): pointers and count 0; fifo_out_valid=0; fifo_out=0; overflow/underflow=0.
//   free_slots=FIFO_DEPTH; hwm_slots=0. Storage array is not reset.
//  fifo_in_stall = (free_slots <= STALL_AT) | (OVERRIDE_EN & fifo_in_stall_override). Combinational.
//   With STALL_AT=0 this means stall only when full.
//  Stall is advisory. A write while full is dropped; fifo_overflow pulses next cycle; state is unchanged.
//  A write while not full but stalled is accepted.
//  ren = fifo_out_valid & fifo_out_ack. fifo_out_ack while empty: no pop; fifo_underflow pulses next cycle.
//  Latency: write in cycle N -> fifo_out_valid=1 and data on fifo_out in cycle N+1.
//   The FIFO is never write-through in the same cycle.
//  Simultaneous wen & ren:
//   - count unchanged, both pointers advance.
//   - When full, the write is accepted because the pop frees a slot; no overflow.
//   - When empty, ren=0, so it is a plain write.
//  Pointers advance modulo FIFO_DEPTH: FIFO_DEPTH-1 -> 0. Count is held explicitly and is 0..FIFO_DEPTH.
//   Full = count==FIFO_DEPTH; empty = count==0.
//  clear=1: next cycle count=0 and pointers=0. It overrides wen/ren in the same cycle.
//   No overflow/underflow is flagged in a clear cycle. Storage contents are untouched.
//  All comparisons use CNT_W-bit unsigned values. STALL_AT is zero-extended to CNT_W.
//  Reset mid-operation discards all contents. The first write after rst_n rises behaves as into an empty FIFO.
// CONFIGURATION
//  Macro CR_KME_FIFO_NG_HWM_EN.
//  Defined: hwm_slots registers the max used_slots seen since reset or clear.
//   It updates the cycle after used_slots rises. clear sets it to 0.
//  Undefined: hwm_slots is tied to 0 and no tracking flop is built.
// STRUCTURE
//  Shared package cr_kme_fifo_pkg:
//   - function cr_kme_fifo_cnt_w(depth) returning $clog2(depth+1)
//   - typedef of overflow/underflow status struct, reused by other KME FIFOs
//  Sub-module cr_kme_fifo_ng_ptr:
//   - modulo-FIFO_DEPTH pointer register with inc and clr inputs
//   - instantiated twice: rd and wr
//  Storage is an inline register array in the top module.
// TESTING
//  1 DEPTH=3,STALL_AT=0: write A,B,C -> used=3, free=0, stall=1; write D -> overflow pulse 1 cycle; pop -> A,B,C in order, D absent.
//  2 DEPTH=5,STALL_AT=2: 3 writes -> stall=1 at free=2.
//    Pop 1 -> stall=0. Wrap test: 12 push/pop pairs -> data order preserved across pointer wrap 4->0.
//  3 Full FIFO, DEPTH=3: wen & ack same cycle -> no overflow; used stays 3; head advances.
//  4 Empty: fifo_out_ack=1 -> underflow pulse; fifo_out=0; valid=0. Write X -> valid=1 and fifo_out=X next cycle.
//  5 OVERRIDE_EN=1, override=1 on empty FIFO -> stall=1. OVERRIDE_EN=0, override=1 -> stall=0.
//  6 2 entries, then clear with wen=1 -> used=0, valid=0, no overflow; hwm=0 (macro on).
//    Then 3 writes -> hwm=3. Assert rst_n=0 mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cr_kme_fifo_pkg.sv
// cr_kme_fifo_pkg: width helpers and status struct shared by the KME FIFOs.
// Revision: 1.0
`default_nettype none
package cr_kme_fifo_pkg;

    function automatic int cr_kme_fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int cr_kme_fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } cr_kme_fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/cr_kme_fifo_ng_ptr.sv
// cr_kme_fifo_ng_ptr: modulo-DEPTH pointer with synchronous clear (clr beats inc).
// Revision: 1.0
`default_nettype none
module cr_kme_fifo_ng_ptr
    import cr_kme_fifo_pkg::*;
#(
    parameter int DEPTH = 3,
    localparam int PTR_W = cr_kme_fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cr_kme_fifo_ng.sv
// cr_kme_fifo_ng: fall-through KME staging FIFO, any depth, advisory stall threshold.
// Optional macro CR_KME_FIFO_NG_HWM_EN enables high-watermark tracking. Revision: 1.0
`default_nettype none
module cr_kme_fifo_ng
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_SIZE   = 128,
    parameter int FIFO_DEPTH  = 3,
    parameter int STALL_AT    = 0,
    parameter int OVERRIDE_EN = 0,
    localparam int CNT_W      = cr_kme_fifo_cnt_w(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [DATA_SIZE-1:0] fifo_in,
    input  logic                 fifo_in_valid,
    input  logic                 fifo_in_stall_override,
    output logic                 fifo_in_stall,
    output logic [DATA_SIZE-1:0] fifo_out,
    output logic                 fifo_out_valid,
    input  logic                 fifo_out_ack,
    output logic                 fifo_overflow,
    output logic                 fifo_underflow,
    output logic [CNT_W-1:0]     used_slots,
    output logic [CNT_W-1:0]     free_slots,
    output logic [CNT_W-1:0]     hwm_slots
);

    localparam int   PTR_W = cr_kme_fifo_ptr_w(FIFO_DEPTH);
    localparam logic OVR   = (OVERRIDE_EN != 0);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    cr_kme_fifo_status_t  status;
    logic                 full;
    logic                 empty;
    logic                 ren;
    logic                 wen;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign ren   = !empty && fifo_out_ack;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is accepted then.
    assign wen   = fifo_in_valid && (!full || ren);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wen && !ren) begin
            count <= count + 1'b1;
        end else if (ren && !wen) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else begin
            status.overflow  <= !clear && fifo_in_valid && full && !ren;
            status.underflow <= !clear && fifo_out_ack && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wen && !clear) begin
            mem[wr_ptr] <= fifo_in;
        end
    end

    cr_kme_fifo_ng_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (wen),
        .ptr   (wr_ptr)
    );

    cr_kme_fifo_ng_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (ren),
        .ptr   (rd_ptr)
    );

    assign fifo_out       = empty ? '0 : mem[rd_ptr];
    assign fifo_out_valid = !empty;
    assign fifo_overflow  = status.overflow;
    assign fifo_underflow = status.underflow;
    assign used_slots     = count;
    assign free_slots     = CNT_W'(FIFO_DEPTH) - count;
    assign fifo_in_stall  = (free_slots <= CNT_W'(STALL_AT)) || (OVR && fifo_in_stall_override);

`ifdef CR_KME_FIFO_NG_HWM_EN
    logic [CNT_W-1:0] hwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (clear) begin
            hwm <= '0;
        end else if (count > hwm) begin
            hwm <= count;
        end
    end

    assign hwm_slots = hwm;
`else
    assign hwm_slots = '0;
`endif

endmodule
`default_nettype wire
